// File: rtl/exe_mem_req.sv
// rtl/exe_mem_req.sv - EX-stage data SRAM request issuer with misalign detect and flushed-response tracking
module exe_mem_req #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_valid,
    input  logic        ms_allowin,
    input  logic [7:0]  mem_op,
    input  logic [31:0] vaddr,
    input  logic [31:0] st_data,
    input  logic        es_ex,
    input  logic        ms_ex,
    input  logic        flush,
    input  logic        ms_wait,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    output logic        es_mem_ready_go,
    output logic        es_ale,
    output logic [1:0]  es_addr_lowbits,
    output logic        drop_data_ok,
    output logic        cancel_full
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cancelled;
    logic [1:0]       lowbits_q;

    logic        is_w, is_h, is_b, is_st;
    logic        issue_ok, inc, dec;
    logic [1:0]  size_nxt;
    logic [3:0]  wstrb_nxt;
    logic [31:0] wdata_nxt;

    // mem_op bits: 7 st_b, 6 st_h, 5 st_w, 4 ld_hu, 3 ld_h, 2 ld_bu, 1 ld_b, 0 ld_w
    assign is_w  = mem_op[0] | mem_op[5];
    assign is_h  = mem_op[3] | mem_op[4] | mem_op[6];
    assign is_b  = mem_op[1] | mem_op[2] | mem_op[7];
    assign is_st = |mem_op[7:5];

    assign es_ale      = es_valid & ((is_w & |vaddr[1:0]) | (is_h & vaddr[0]));
    assign cancel_full = (cnt == CNT_MAX);
    assign issue_ok    = es_valid & |mem_op & ~es_ale & ~es_ex & ~ms_ex & ~flush & ~cancel_full;

    always_comb begin
        size_nxt  = 2'd0;
        wstrb_nxt = 4'b0000;
        wdata_nxt = st_data;
        if (is_w)
            size_nxt = 2'd2;
        else if (is_h)
            size_nxt = 2'd1;
        if (mem_op[7]) begin
            wstrb_nxt = 4'b0001 << vaddr[1:0];
            wdata_nxt = {4{st_data[7:0]}};
        end else if (mem_op[6]) begin
            wstrb_nxt = vaddr[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{st_data[15:0]}};
        end else if (mem_op[5]) begin
            wstrb_nxt = 4'hF;
        end
    end

    // A flush that lands before or with addr_ok still leaves a response in flight
    assign inc = ((state == REQ) & data_sram_addr_ok & (cancelled | flush))
               | ((state == WAIT) & flush);
    assign dec = data_sram_data_ok & (cnt != '0) & ~ms_wait;
    assign drop_data_ok = dec;

    assign data_sram_req   = (state == REQ);
    assign es_addr_lowbits = (state == IDLE) ? vaddr[1:0] : lowbits_q;

    always_comb begin
        es_mem_ready_go = 1'b1;
        case (state)
            IDLE:    es_mem_ready_go = ~|mem_op | es_ale | es_ex;
            REQ:     es_mem_ready_go = data_sram_addr_ok & ~cancelled & ~flush;
            default: es_mem_ready_go = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            cnt             <= '0;
            cancelled       <= 1'b0;
            lowbits_q       <= 2'd0;
            data_sram_wr    <= 1'b0;
            data_sram_size  <= 2'd0;
            data_sram_wstrb <= 4'd0;
            data_sram_addr  <= 32'd0;
            data_sram_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_ok) begin
                        state           <= REQ;
                        lowbits_q       <= vaddr[1:0];
                        data_sram_wr    <= is_st;
                        data_sram_size  <= is_b ? 2'd0 : size_nxt;
                        data_sram_wstrb <= wstrb_nxt;
                        data_sram_addr  <= vaddr;
                        data_sram_wdata <= wdata_nxt;
                    end
                end
                REQ: begin
                    if (data_sram_addr_ok) begin
                        cancelled <= 1'b0;
                        if (cancelled | flush | ms_allowin)
                            state <= IDLE;
                        else
                            state <= WAIT;
                    end else if (flush) begin
                        cancelled <= 1'b1;
                    end
                end
                WAIT: begin
                    if (flush | ms_allowin)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (inc & ~dec & ~cancel_full)
                cnt <= cnt + CNT_ONE;
            else if (dec & ~inc)
                cnt <= cnt - CNT_ONE;
        end
    end
endmodule

// File: doc/exe_mem_req.md
Name: exe_mem_req

Overview:
Data-side request issuer for the execute stage. It sits directly upstream of the memory stage. For each valid load or store in EX it generates the SRAM-like request: address, size, write strobe and aligned write data. It holds the request until addr_ok, detects misaligned accesses (ALE), and gates EX ready_go. It also counts accepted requests whose instruction was flushed, so the memory stage can discard their data_ok responses.

Parameters:
CNT_W, 2, width of the cancelled-response counter (maximum 2^CNT_W-1 outstanding cancelled responses).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
es_valid  in  1  EX holds a valid instruction
ms_allowin  in  1  memory stage can accept
mem_op  in  8  one-hot {st_b,st_h,st_w,ld_hu,ld_h,ld_bu,ld_b,ld_w}; all zero = no memory op
vaddr  in  32  effective address (ALU result)
st_data  in  32  rk register value for stores
es_ex  in  1  EX instruction already carries an exception
ms_ex  in  1  exception or ertn pending in MS/WB; suppresses new issue
flush  in  1  final_ex or ertn flush
ms_wait  in  1  MS has an older request still awaiting data_ok
data_sram_req  out  1  request valid
data_sram_wr  out  1  1 = store
data_sram_size  out  2  0 = byte, 1 = half, 2 = word
data_sram_wstrb  out  4  byte enables; 0 for loads
data_sram_addr  out  32  request address
data_sram_wdata  out  32  replicated store data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  response returned
es_mem_ready_go  out  1  EX may advance
es_ale  out  1  address-misaligned exception for the current instruction
es_addr_lowbits  out  2  vaddr[1:0], forwarded to MS
drop_data_ok  out  1  current data_ok belongs to a cancelled request
cancel_full  out  1  cancelled-response counter saturated

Behaviour:
- Async reset: state = IDLE, cnt = 0, cancelled = 0, latched fields = 0. All outputs are 0 except es_mem_ready_go, which is 1 (no memory op).
- ALE (combinational):
  - ld_w/st_w with vaddr[1:0] != 0.
  - ld_h/ld_hu/st_h with vaddr[0] = 1.
  - es_ale = es_valid & ALE condition.
- issue_ok = es_valid & |mem_op & ~es_ale & ~es_ex & ~ms_ex & ~flush & ~cancel_full.
- Field encoding:
  - size: b/bu = 0, h/hu = 1, w = 2.
  - wdata: st_b = {4{st_data[7:0]}}, st_h = {2{st_data[15:0]}}, st_w = st_data.
  - wstrb: st_b = 4'b0001<<vaddr[1:0], st_h = vaddr[1] ? 4'b1100 : 4'b0011, st_w = 4'hF, loads = 0.
- States:
  - IDLE:
    - If issue_ok: latch addr/size/wr/wstrb/wdata, go to REQ. Issue latency is 1 cycle.
    - es_mem_ready_go = ~|mem_op | es_ale | es_ex.
  - REQ:
    - data_sram_req = 1; all request fields are stable until addr_ok. The request is never withdrawn.
    - On addr_ok: if cancelled or flush, go to IDLE, cnt++, clear cancelled. Else if ms_allowin, go to IDLE; else go to WAIT.
    - Flush without addr_ok: set cancelled, stay in REQ.
    - es_mem_ready_go = addr_ok & ~cancelled & ~flush.
  - WAIT:
    - es_mem_ready_go = 1.
    - If flush: go to IDLE, cnt++.
    - Else if ms_allowin: go to IDLE.
- Counter:
  - Decrement when data_sram_data_ok & cnt != 0 & ~ms_wait.
  - Simultaneous increment and decrement leaves cnt unchanged.
  - Never wraps: cancel_full = (cnt == 2^CNT_W-1), which blocks issue.
- drop_data_ok = data_sram_data_ok & cnt != 0 & ~ms_wait.
- es_addr_lowbits = vaddr[1:0] in IDLE, latched value otherwise.
- es_valid low in IDLE: no request, ready_go is don't-care.
- Reset mid-request: the request drops immediately and cnt clears.

Test Plan:
- st.h, vaddr 0x1000_0002, st_data 0x0000_ABCD, addr_ok in the 2nd REQ cycle, ms_allowin = 1 -> req high for 2 cycles, size = 1, wstrb = 4'b1100, wdata = 0xABCD_ABCD, wr = 1, ready_go high on the addr_ok cycle, state IDLE next.
- ld.w, vaddr 0x2000_0001 -> es_ale = 1, data_sram_req stays 0, es_mem_ready_go = 1 in the same cycle.
- ld.b, vaddr 0x3, flush asserted in the 1st REQ cycle, addr_ok 3 cycles later -> req held until addr_ok, es_mem_ready_go = 0 throughout, cnt = 1. The next data_ok with ms_wait = 0 gives drop_data_ok = 1 and cnt = 0.
- st.w accepted, ms_allowin = 0 for 4 cycles -> WAIT, req = 0, ready_go = 1; IDLE on the cycle ms_allowin rises.
- 3 flushed accepted requests with no data_ok -> cancel_full = 1; a new ld.w is not issued until one data_ok (ms_wait = 0) decrements cnt to 2.
- resetn low while in REQ -> req = 0, cnt = 0, state IDLE immediately (asynchronous).
